// File: rtl/pmt_gate_pkg.sv
// Shared types and default widths for the PMT gate sequencer.
package pmt_gate_pkg;

  localparam int unsigned GATE_W_DEF = 16;
  localparam int unsigned GAP_W_DEF  = 8;
  localparam int unsigned PAIR_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GATE_A = 3'd1,
    GAP_A  = 3'd2,
    GATE_B = 3'd3,
    GAP_B  = 3'd4
  } state_e;

endpackage

// File: rtl/pmt_gate_timer.sv
// Loadable down-counter with registered zero flag; a zero length loads as one cycle.
module pmt_gate_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] len_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         zero_q;

  // Loading len-1 makes zero_o mark the last cycle of the interval.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = (len_i == '0) ? '0 : len_i - W'(1);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/pmt_gate_sequencer.sv
// A/B gate-pair sequencer driving the PMT hold-value counter.
// Optional abort input enabled by defining PMT_GATE_ABORT_EN.
module pmt_gate_sequencer
  import pmt_gate_pkg::*;
#(
  parameter int unsigned GATE_W = GATE_W_DEF,
  parameter int unsigned GAP_W  = GAP_W_DEF,
  parameter int unsigned PAIR_W = PAIR_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  input  logic [GAP_W-1:0]  gap_len,
  input  logic [PAIR_W-1:0] num_pairs,
`ifdef PMT_GATE_ABORT_EN
  input  logic              abort,
`endif
  output logic              sw_count,
  output logic              toggle,
  output logic              busy,
  output logic              done,
  output logic [PAIR_W-1:0] pair_idx
);

  state_e              state_q, state_d;
  logic [GATE_W-1:0]   gate_len_q;
  logic [GAP_W-1:0]    gap_len_q;
  logic [PAIR_W-1:0]   num_pairs_q;
  logic [PAIR_W-1:0]   pair_q, pair_d;
  logic                sw_count_q, toggle_q, busy_q, done_q, done_d;
  logic                latch_cfg;
  logic                gate_load, gate_dec, gate_zero;
  logic                gap_load, gap_dec, gap_zero;
  logic [GATE_W-1:0]   gate_len_sel;

  // The first gate load coincides with the config latch, so take the live input then.
  assign gate_len_sel = (state_q == IDLE) ? gate_len : gate_len_q;

  pmt_gate_timer #(.W(GATE_W)) u_gate_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .load_i  (gate_load),
    .dec_i   (gate_dec),
    .len_i   (gate_len_sel),
    .zero_o  (gate_zero)
  );

  pmt_gate_timer #(.W(GAP_W)) u_gap_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .load_i  (gap_load),
    .dec_i   (gap_dec),
    .len_i   (gap_len_q),
    .zero_o  (gap_zero)
  );

  always_comb begin
    state_d   = state_q;
    pair_d    = pair_q;
    done_d    = 1'b0;
    latch_cfg = 1'b0;
    gate_load = 1'b0;
    gate_dec  = 1'b0;
    gap_load  = 1'b0;
    gap_dec   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          latch_cfg = 1'b1;
          pair_d    = '0;
          if (num_pairs == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = GATE_A;
            gate_load = 1'b1;
          end
        end
      end
      GATE_A: begin
        if (gate_zero) begin
          state_d  = GAP_A;
          gap_load = 1'b1;
        end else begin
          gate_dec = 1'b1;
        end
      end
      GAP_A: begin
        if (gap_zero) begin
          state_d   = GATE_B;
          gate_load = 1'b1;
        end else begin
          gap_dec = 1'b1;
        end
      end
      GATE_B: begin
        if (gate_zero) begin
          if (pair_q == num_pairs_q - PAIR_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d  = GAP_B;
            gap_load = 1'b1;
          end
        end else begin
          gate_dec = 1'b1;
        end
      end
      GAP_B: begin
        if (gap_zero) begin
          state_d   = GATE_A;
          gate_load = 1'b1;
          pair_d    = pair_q + PAIR_W'(1);
        end else begin
          gap_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef PMT_GATE_ABORT_EN
    if (abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      pair_d    = pair_q;
      done_d    = 1'b0;
      gate_load = 1'b0;
      gate_dec  = 1'b0;
      gap_load  = 1'b0;
      gap_dec   = 1'b0;
    end
`endif
  end

  // Outputs are registered from the next state so they align with state_q.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pair_q      <= '0;
      gate_len_q  <= '0;
      gap_len_q   <= '0;
      num_pairs_q <= '0;
      sw_count_q  <= 1'b0;
      toggle_q    <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pair_q     <= pair_d;
      if (latch_cfg) begin
        gate_len_q  <= gate_len;
        gap_len_q   <= gap_len;
        num_pairs_q <= num_pairs;
      end
      sw_count_q <= (state_d == GATE_A) || (state_d == GATE_B);
      toggle_q   <= (state_d == IDLE) || (state_d == GATE_A) || (state_d == GAP_B);
      busy_q     <= (state_d != IDLE);
      done_q     <= done_d;
    end
  end

  assign sw_count = sw_count_q;
  assign toggle   = toggle_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pair_idx = pair_q;

endmodule
